// File: rtl/awgn_pkg.sv
// awgn_pkg: definitions shared by awgn2 and awgn_stats.
//   SW        - sample width (signed Q5.11)
//   FRAC_BITS - fraction bits of the sample Q-format
//   state_t   - awgn_stats FSM encoding
package awgn_pkg;

  localparam int SW        = 16;
  localparam int FRAC_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/awgn_acc.sv
// awgn_acc: per-sample arithmetic and accumulators of awgn_stats.
//   clk, reset   - clock, async active-low reset
//   clr          - synchronous clear of all accumulators
//   en           - accumulate x this cycle
//   x            - signed sample
//   thresh       - unsigned outlier magnitude threshold
//   avg          - sum of samples >>> LOG2N (floor)
//   avg_sq       - sum of squares >> LOG2N (truncated)
//   ocnt         - number of samples with |x| > thresh
module awgn_acc
  import awgn_pkg::*;
#(
  parameter int LOG2N = 10,
  parameter int SW    = awgn_pkg::SW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [SW-1:0]       x,
  input  logic [SW-2:0]       thresh,
  output logic [SW-1:0]       avg,
  output logic [2*SW-1:0]     avg_sq,
  output logic [LOG2N:0]      ocnt
);

  localparam int SUMW = SW + LOG2N;
  localparam int SQW  = 2 * SW + LOG2N;

  logic [SUMW-1:0]     sum;
  logic [SQW-1:0]      sumsq;
  logic signed [SW:0]  xe;
  logic [SW:0]         mag;
  logic signed [2*SW-1:0] sq_s;
  logic                hit;

  // One extra bit so that the most negative sample has a representable magnitude
  assign xe   = {x[SW-1], x};
  assign mag  = xe[SW] ? unsigned'(-xe) : unsigned'(xe);
  assign hit  = mag > {2'b00, thresh};
  // A square is never negative and (-2^(SW-1))^2 = 2^(2SW-2) still fits 2*SW bits
  assign sq_s = $signed(x) * $signed(x);

  // N = 2^LOG2N samples, so the division by N is a plain bit select;
  // taking the top bits of a two's-complement sum is an arithmetic floor shift.
  assign avg    = sum[SUMW-1:LOG2N];
  assign avg_sq = sumsq[SQW-1:LOG2N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum   <= '0;
      sumsq <= '0;
      ocnt  <= '0;
    end else if (clr) begin
      sum   <= '0;
      sumsq <= '0;
      ocnt  <= '0;
    end else if (en) begin
      sum   <= sum + {{LOG2N{x[SW-1]}}, x};
      sumsq <= sumsq + {{LOG2N{1'b0}}, unsigned'(sq_s)};
      ocnt  <= ocnt + {{LOG2N{1'b0}}, hit};
    end
  end

endmodule

// File: rtl/awgn_stats.sv
// awgn_stats: block statistics of a noise sample stream.
// Measures N = 2^LOG2N accepted samples and reports mean, mean-square and
// the count of samples whose magnitude exceeds a threshold.
//   clk, reset   - clock, async active-low reset
//   start        - begin a block (IDLE only), latches thresh
//   clear        - abort the block in progress (ACCUM only)
//   in_valid / in_ready / in_sample - sample stream from awgn2
//   thresh       - outlier magnitude threshold
//   busy         - block in ACCUM or DONE
//   done         - one-cycle pulse, results just loaded
//   mean, msq, outlier_cnt - results, held until the next block completes
module awgn_stats
  import awgn_pkg::*;
#(
  parameter int LOG2N = 10,
  parameter int SW    = awgn_pkg::SW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SW-1:0]       in_sample,
  input  logic [SW-2:0]       thresh,
  output logic                busy,
  output logic                done,
  output logic [SW-1:0]       mean,
  output logic [2*SW-1:0]     msq,
  output logic [LOG2N:0]      outlier_cnt
);

  state_t             state;
  logic [LOG2N-1:0]   cnt;
  logic [SW-2:0]      thr_q;
  logic               acc_clr;
  logic               acc_en;
  logic               last;
  logic [SW-1:0]      avg;
  logic [2*SW-1:0]    avg_sq;
  logic [LOG2N:0]     ocnt;

  assign in_ready = (state == ST_ACCUM);
  assign busy     = (state != ST_IDLE);
  assign last     = &cnt;
  assign acc_clr  = (state == ST_IDLE) && start;
  // clear wins over a coincident sample, so that sample never reaches the sums
  assign acc_en   = in_ready && in_valid && !clear;

  awgn_acc #(.LOG2N(LOG2N), .SW(SW)) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clr    (acc_clr),
    .en     (acc_en),
    .x      (in_sample),
    .thresh (thr_q),
    .avg    (avg),
    .avg_sq (avg_sq),
    .ocnt   (ocnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      thr_q       <= '0;
      done        <= 1'b0;
      mean        <= '0;
      msq         <= '0;
      outlier_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ACCUM;
            cnt   <= '0;
            thr_q <= thresh;
          end
        end
        ST_ACCUM: begin
          if (clear) begin
            state <= ST_IDLE;
          end else if (in_valid) begin
            cnt <= cnt + 1'b1;
            if (last) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Accumulators are complete here; the Nth sample landed last edge
          state       <= ST_IDLE;
          mean        <= avg;
          msq         <= avg_sq;
          outlier_cnt <= ocnt;
          done        <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_awgn_stats.sv
module tb_awgn_stats;

  localparam int LOG2N = 2;
  localparam int N     = 4;
  localparam int SW    = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               start, clear, in_valid, in_ready;
  logic [SW-1:0]      in_sample;
  logic [SW-2:0]      thresh;
  logic               busy, done;
  logic signed [SW-1:0] mean;
  logic [2*SW-1:0]    msq;
  logic [LOG2N:0]     outlier_cnt;

  int total = 0;
  int bad   = 0;
  longint pm = 0, pq = 0, po = 0;  // last results the DUT should be holding

  awgn_stats #(.LOG2N(LOG2N), .SW(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sample   (in_sample),
    .thresh      (thresh),
    .busy        (busy),
    .done        (done),
    .mean        (mean),
    .msq         (msq),
    .outlier_cnt (outlier_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][15:0] s;
    logic [14:0]      thr;
    int               em;
    longint           eq;
    int               eo;
  } vec_t;

  vec_t vecs[6];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: block statistics straight from the definition
  function automatic void model(input logic [3:0][15:0] s, input logic [14:0] thr,
                                output longint m, output longint q, output longint o);
    longint sum, sq, v, a;
    sum = 0; sq = 0; o = 0;
    for (int i = 0; i < N; i++) begin
      v = longint'($signed(s[i]));
      sum += v;
      sq  += v * v;
      a = (v < 0) ? -v : v;
      if (a > longint'(thr)) o++;
    end
    m = sum / N;
    if ((sum % N) != 0 && sum < 0) m = m - 1;
    q = sq / N;
  endfunction

  task automatic run_block(input logic [3:0][15:0] s, input logic [14:0] thr,
                           input longint em, input longint eq, input longint eo,
                           input bit gaps, input string tag);
    int idx, guard;
    bit acc;
    start = 1'b1; thresh = thr; clear = gaps;   // clear in IDLE must not matter
    cyc();
    start = 1'b0; clear = 1'b0;
    chk({tag, " busy_accum"}, longint'(busy), 1);
    idx = 0; guard = 0;
    in_valid = 1'b0;
    while (idx < N && guard < 64) begin
      in_valid  = gaps ? ~in_valid : 1'b1;
      start     = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      in_sample = s[idx];
      acc = in_valid && in_ready;
      cyc();
      if (acc) idx++;
      guard++;
    end
    chk({tag, " no_timeout"}, longint'(guard < 64), 1);
    in_valid = 1'b0; start = gaps; clear = gaps;   // both ignored in DONE
    chk({tag, " done_early"}, longint'(done), 0);
    chk({tag, " busy_done"}, longint'(busy), 1);
    cyc();
    start = 1'b0; clear = 1'b0;
    chk({tag, " done"}, longint'(done), 1);
    chk({tag, " mean"}, longint'(mean), em);
    chk({tag, " msq"}, longint'(msq), eq);
    chk({tag, " ocnt"}, longint'(outlier_cnt), eo);
    chk({tag, " busy_idle"}, longint'(busy), 0);
    cyc();
    chk({tag, " done_1cyc"}, longint'(done), 0);
    chk({tag, " no_restart"}, longint'(busy), 0);
    chk({tag, " mean_hold"}, longint'(mean), em);
    pm = em; pq = eq; po = eo;
  endtask

  initial begin
    logic [3:0][15:0] rs;
    logic [14:0] rt;
    longint m, q, o;

    vecs[0] = '{s: {16'd2048, 16'd2048, 16'd2048, 16'd2048}, thr: 15'd4096,
                em: 2048, eq: 64'd4194304, eo: 0};
    vecs[1] = '{s: {16'h8000, 16'h8000, 16'h8000, 16'h8000}, thr: 15'd0,
                em: -32768, eq: 64'd1073741824, eo: 4};
    vecs[2] = '{s: {16'd0, 16'd0, 16'd0, 16'd1}, thr: 15'd0, em: 0, eq: 0, eo: 1};
    vecs[3] = '{s: {16'd0, 16'd0, 16'd0, 16'hFFFF}, thr: 15'd0, em: -1, eq: 0, eo: 1};
    vecs[4] = '{s: {-16'sd400, 16'sd300, -16'sd200, 16'sd100}, thr: 15'd250,
                em: -50, eq: 64'd75000, eo: 2};
    vecs[5] = '{s: {16'd0, 16'd0, 16'd32767, 16'h8000}, thr: 15'd32767,
                em: -1, eq: 64'd536854528, eo: 1};

    reset = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_sample = '0; thresh = '0;
    cyc(); cyc();
    chk("rst busy", longint'(busy), 0);
    chk("rst in_ready", longint'(in_ready), 0);
    chk("rst done", longint'(done), 0);
    chk("rst mean", longint'(mean), 0);
    chk("rst msq", longint'(msq), 0);
    chk("rst ocnt", longint'(outlier_cnt), 0);
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i].s, vecs[i].thr, longint'(vecs[i].em), vecs[i].eq,
                longint'(vecs[i].eo), 1'b0, $sformatf("vec%0d", i));
      run_block(vecs[i].s, vecs[i].thr, longint'(vecs[i].em), vecs[i].eq,
                longint'(vecs[i].eo), 1'b1, $sformatf("vec%0dg", i));
    end

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N; k++)
        rs[k] = (i % 2 == 0) ? 16'($urandom) : 16'($signed(11'($urandom)));
      rt = 15'($urandom_range(0, 3000));
      model(rs, rt, m, q, o);
      run_block(rs, rt, m, q, o, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // clear coincident with the 4th sample: block dropped, results held
    start = 1'b1; thresh = 15'd10;
    cyc();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1; in_sample = 16'd1000;
      clear = (k == N - 1);
      cyc();
    end
    in_valid = 1'b0; clear = 1'b0;
    chk("clr busy", longint'(busy), 0);
    chk("clr in_ready", longint'(in_ready), 0);
    chk("clr done", longint'(done), 0);
    chk("clr mean_held", longint'(mean), pm);
    chk("clr msq_held", longint'(msq), pq);
    chk("clr ocnt_held", longint'(outlier_cnt), po);
    in_valid = 1'b1;
    cyc();
    chk("clr no_done_late", longint'(done), 0);
    chk("clr stays_idle", longint'(busy), 0);
    in_valid = 1'b0;

    // reset mid-block: outputs drop immediately, block waits for start after
    start = 1'b1;
    cyc();
    start = 1'b0;
    in_valid = 1'b1; in_sample = 16'd500;
    cyc(); cyc();
    #2 reset = 1'b0;
    #1;
    chk("mrst busy", longint'(busy), 0);
    chk("mrst in_ready", longint'(in_ready), 0);
    chk("mrst mean", longint'(mean), 0);
    chk("mrst msq", longint'(msq), 0);
    chk("mrst ocnt", longint'(outlier_cnt), 0);
    chk("mrst done", longint'(done), 0);
    cyc();
    reset = 1'b1;
    cyc(); cyc();
    chk("mrst wait_start", longint'(busy), 0);
    in_valid = 1'b0;
    model(vecs[4].s, vecs[4].thr, m, q, o);
    run_block(vecs[4].s, vecs[4].thr, m, q, o, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
